// File: rtl/mux_memoria_param_pkg.sv
// Shared mode encoding and index helpers for the parametrised registered mux.
package mux_memoria_param_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   // Channel index after idx, wrapping at n (n need not be a power of 2).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_memoria_param_if.sv
// Producer-side channels plus single consumer-side handshake of the registered mux.
interface mux_memoria_param_if #(
   parameter int WIDTH = 2,
   parameter int NCH   = 4,
   parameter int SELW  = 2
);
   logic                  mode;
   logic [SELW-1:0]       selector;
   logic [NCH-1:0]        valid_in;
   logic [NCH*WIDTH-1:0]  data_in;
   logic [NCH-1:0]        ready_in;
   logic                  valid_out;
   logic                  ready_out;
   logic [WIDTH-1:0]      data_out;
   logic [SELW-1:0]       chan_out;

   modport master (
      output mode, selector, valid_in, data_in, ready_out,
      input  ready_in, valid_out, data_out, chan_out
   );

   modport slave (
      input  mode, selector, valid_in, data_in, ready_out,
      output ready_in, valid_out, data_out, chan_out
   );
endinterface

// File: rtl/mux_memoria_param_rr_arbiter.sv
// Combinational round-robin pick: first asserted req scanning from ptr upward, wrapping at NCH.
// ptr is assumed to be below NCH.
module rr_arbiter #(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   int idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      // Walk offsets from farthest to nearest so the closest request to ptr wins.
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_memoria_param.sv
// NCH:1 registered mux, explicit-selector or round-robin; 1-cycle latency, 1 word/cycle.
// Output register loads when empty or drained; stalls freeze all outputs and withhold ready_in.
module mux_memoria_param
   import mux_memoria_param_pkg::*;
#(
   parameter int WIDTH        = 2,
   parameter int NCH          = 4,
   parameter int SELW         = 2,
   parameter bit HOLD_ON_IDLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   mux_memoria_param_if.slave    bus
);

   generate
      if (SELW != $clog2(NCH) || NCH < 2 || NCH > 16) begin : g_param_check
         $error("mux_memoria_param: NCH must be 2..16 and SELW must equal clog2(NCH)");
      end
   endgenerate

   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [SELW-1:0]   chan_q, chan_d;
   logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;

   logic              rr_vld;
   logic [SELW-1:0]   rr_idx;
   logic              accept;
   logic              cand_vld;
   logic [SELW-1:0]   cand;
   logic              grant;
   logic              xfer;
   logic [NCH-1:0]    ready_c;

   rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_rr_arbiter (
      .req       (bus.valid_in),
      .ptr       (rr_ptr_q),
      .gnt_valid (rr_vld),
      .gnt_idx   (rr_idx)
   );

   // In selector mode the grant ignores valid_in so ready_in never waits on the producer.
   always_comb begin
      accept   = ~valid_q | bus.ready_out;
      cand     = bus.selector;
      cand_vld = (int'(bus.selector) < NCH);
      if (bus.mode == MODE_RR) begin
         cand     = rr_idx;
         cand_vld = rr_vld;
      end
      grant   = cand_vld & accept & ~reset;
      ready_c = '0;
      if (grant) begin
         ready_c[cand] = 1'b1;
      end
      xfer = grant & bus.valid_in[cand];
   end

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      chan_d   = chan_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = bus.data_in[int'(cand)*WIDTH +: WIDTH];
         chan_d  = cand;
         if (bus.mode == MODE_RR) begin
            rr_ptr_d = SELW'(wrap_inc(int'(cand), NCH));
         end
      end else if (bus.ready_out) begin
         valid_d = 1'b0;
         if (!HOLD_ON_IDLE) begin
            data_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         chan_q   <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         chan_q   <= chan_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.ready_in  = ready_c;
   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.chan_out  = chan_q;

endmodule

// File: tb/tb_mux_memoria_param.sv
// Bench for mux_memoria_param: a 4-channel hold-on-idle instance and a 3-channel clear-on-idle
// instance share stimulus; a behavioural model is compared every cycle, plus literal expectations.
module tb_mux_memoria_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_memoria_param_if #(.WIDTH(2), .NCH(4), .SELW(2)) bus4();
   mux_memoria_param_if #(.WIDTH(2), .NCH(3), .SELW(2)) bus3();

   assign bus3.mode      = bus4.mode;
   assign bus3.selector  = bus4.selector;
   assign bus3.valid_in  = bus4.valid_in[2:0];
   assign bus3.data_in   = bus4.data_in[5:0];
   assign bus3.ready_out = bus4.ready_out;

   mux_memoria_param #(.WIDTH(2), .NCH(4), .SELW(2), .HOLD_ON_IDLE(1'b1)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   mux_memoria_param #(.WIDTH(2), .NCH(3), .SELW(2), .HOLD_ON_IDLE(1'b0)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.slave)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int vout;
      int dout;
      int cout;
      int ptr;
   } mst_t;

   mst_t m4, m3;

   // Granted channel for this cycle, or -1.
   function automatic int grant_of(mst_t s, int nch, logic md, int sel, int vin,
                                   logic rout, logic rst);
      if (rst) return -1;
      if (s.vout != 0 && !rout) return -1;
      if (md == 1'b0) return (sel < nch) ? sel : -1;
      for (int k = 0; k < nch; k++) begin
         if (((vin >> ((s.ptr + k) % nch)) & 1) != 0) return (s.ptr + k) % nch;
      end
      return -1;
   endfunction

   function automatic mst_t next_of(mst_t s, int nch, int hold, logic md, int sel, int vin,
                                    int din, logic rout, logic rst);
      mst_t n;
      int   g;
      n = s;
      if (rst) begin
         n.vout = 0; n.dout = 0; n.cout = 0; n.ptr = 0;
         return n;
      end
      g = grant_of(s, nch, md, sel, vin, rout, rst);
      if (g >= 0 && ((vin >> g) & 1) != 0) begin
         n.vout = 1;
         n.dout = (din >> (2 * g)) & 3;
         n.cout = g;
         if (md) n.ptr = (g + 1) % nch;
      end else if (rout) begin
         n.vout = 0;
         if (hold == 0) n.dout = 0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m4 <= next_of(m4, 4, 1, bus4.mode, int'(bus4.selector), int'(bus4.valid_in),
                    int'(bus4.data_in), bus4.ready_out, reset);
      m3 <= next_of(m3, 3, 0, bus3.mode, int'(bus3.selector), int'(bus3.valid_in),
                    int'(bus3.data_in), bus3.ready_out, reset);
   end

   always @(negedge clk) begin : compare
      int g4, g3;
      if (chk_en) begin
         g4 = grant_of(m4, 4, bus4.mode, int'(bus4.selector), int'(bus4.valid_in),
                       bus4.ready_out, reset);
         g3 = grant_of(m3, 3, bus3.mode, int'(bus3.selector), int'(bus3.valid_in),
                       bus3.ready_out, reset);
         chk("m4_ready_in",  32'(bus4.ready_in),  (g4 >= 0) ? (32'd1 << g4) : 32'd0);
         chk("m4_valid_out", 32'(bus4.valid_out), m4.vout);
         chk("m4_data_out",  32'(bus4.data_out),  m4.dout);
         chk("m4_chan_out",  32'(bus4.chan_out),  m4.cout);
         chk("m3_ready_in",  32'(bus3.ready_in),  (g3 >= 0) ? (32'd1 << g3) : 32'd0);
         chk("m3_valid_out", 32'(bus3.valid_out), m3.vout);
         chk("m3_data_out",  32'(bus3.data_out),  m3.dout);
         chk("m3_chan_out",  32'(bus3.chan_out),  m3.cout);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int rr_a[5] = '{0, 1, 2, 3, 0};
   int rr_b[4] = '{1, 3, 1, 3};

   initial begin
      reset          = 1'b1;
      bus4.mode      = 1'b0;
      bus4.selector  = 2'd0;
      bus4.valid_in  = 4'b1111;
      bus4.data_in   = 8'b11_10_01_00;
      bus4.ready_out = 1'b1;

      // Reset held two cycles with every channel valid.
      step();
      chk_en = 1'b1;
      step();
      chk("rst_valid_out", 32'(bus4.valid_out), 0);
      chk("rst_data_out",  32'(bus4.data_out),  0);
      chk("rst_chan_out",  32'(bus4.chan_out),  0);
      chk("rst_ready_in",  32'(bus4.ready_in),  0);
      chk("rst_ready_in3", 32'(bus3.ready_in),  0);
      reset = 1'b0;
      #1;
      chk("rel_ready_in", 32'(bus4.ready_in), 32'b0001);
      step();
      chk("rel_valid_out", 32'(bus4.valid_out), 1);

      // Explicit selector.
      bus4.selector = 2'd2;
      bus4.valid_in = 4'b0100;
      bus4.data_in  = 8'b00_11_00_00;
      step();
      chk("sel_valid_out", 32'(bus4.valid_out), 1);
      chk("sel_data_out",  32'(bus4.data_out),  3);
      chk("sel_chan_out",  32'(bus4.chan_out),  2);
      chk("sel_data_out3", 32'(bus3.data_out),  3);
      bus4.valid_in = 4'b0000;
      #1;
      chk("sel_ready_novalid", 32'(bus4.ready_in), 32'b0100);
      step();
      chk("idle_valid_out", 32'(bus4.valid_out), 0);
      chk("idle_hold_data", 32'(bus4.data_out),  3);
      chk("idle_clear_data3", 32'(bus3.data_out), 0);

      // Round-robin fairness.
      bus4.mode     = 1'b1;
      bus4.valid_in = 4'b1111;
      bus4.data_in  = 8'b11_10_01_00;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_all_chan", 32'(bus4.chan_out), rr_a[i]);
         chk("rr_all_data", 32'(bus4.data_out), rr_a[i]);
      end
      bus4.valid_in = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_1010_chan", 32'(bus4.chan_out), rr_b[i]);
      end

      // Backpressure.
      bus4.valid_in = 4'b0010;
      step();
      chk("bp_load_data", 32'(bus4.data_out), 1);
      bus4.ready_out = 1'b0;
      bus4.valid_in  = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready_in", 32'(bus4.ready_in), 0);
         step();
         chk("bp_valid_out", 32'(bus4.valid_out), 1);
         chk("bp_data_out",  32'(bus4.data_out),  1);
         chk("bp_chan_out",  32'(bus4.chan_out),  1);
      end
      bus4.ready_out = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus4.ready_in), 32'b0100);
      step();
      chk("bp_next_chan", 32'(bus4.chan_out), 2);

      // Out-of-range selector on the 3-channel instance.
      bus4.mode     = 1'b0;
      bus4.valid_in = 4'b0000;
      step();
      bus4.selector = 2'd3;
      bus4.valid_in = 4'b1111;
      #1;
      chk("oor_ready_in3", 32'(bus3.ready_in), 0);
      step();
      chk("oor_valid_out3", 32'(bus3.valid_out), 0);
      chk("oor_chan_out4", 32'(bus4.chan_out), 3);
      step();
      chk("oor_valid_out3b", 32'(bus3.valid_out), 0);

      // Reset mid-stream.
      bus4.mode = 1'b1;
      step();
      step();
      chk("mid_valid_before", 32'(bus4.valid_out), 1);
      reset = 1'b1;
      #1;
      chk("mid_ready_in", 32'(bus4.ready_in), 0);
      step();
      chk("mid_valid_out", 32'(bus4.valid_out), 0);
      reset = 1'b0;
      step();
      chk("mid_first_chan", 32'(bus4.chan_out), 0);
      chk("mid_first_valid", 32'(bus4.valid_out), 1);
      step();
      chk("mid_second_chan", 32'(bus4.chan_out), 1);

      // Mixed traffic, checked by the model every cycle.
      for (int i = 0; i < 400; i++) begin
         reset          = ($urandom_range(0, 40) == 0);
         bus4.mode      = 1'($urandom_range(0, 1));
         bus4.selector  = 2'($urandom_range(0, 3));
         bus4.valid_in  = 4'($urandom_range(0, 15));
         bus4.data_in   = 8'($urandom_range(0, 255));
         bus4.ready_out = ($urandom_range(0, 3) != 0);
         step();
      end
      reset = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
